// File: rtl/commit_rrat_pkg.sv
// commit_rrat_pkg
//   Shared types and sizes for the retirement stage (commit_rrat).
//   Contents:
//     P_REG_DEPTH     physical register index width (64 pregs)
//     R_REG_DEPTH     architectural register index width (32 aregs)
//     NUM_AREG        number of architectural registers (2**R_REG_DEPTH)
//     retire_entry_t  one retiring ROB entry {rd, pd, upd, flush}
//     commit_state_t  retirement FSM states {CS_RUN, CS_RECOVER}
package commit_rrat_pkg;

  localparam int P_REG_DEPTH = 6;
  localparam int R_REG_DEPTH = 5;
  localparam int NUM_AREG    = 2 ** R_REG_DEPTH;

  typedef struct packed {
    logic [R_REG_DEPTH-1:0] rd;
    logic [P_REG_DEPTH-1:0] pd;
    logic                   upd;
    logic                   flush;
  } retire_entry_t;

  typedef enum logic {
    CS_RUN     = 1'b0,
    CS_RECOVER = 1'b1
  } commit_state_t;

endpackage

// File: rtl/commit_rrat_if.sv
// commit_rrat_if
//   Bundles the retire input bus, the free-list return, the front-RAT
//   recovery stream and (optionally) the statistics counters.
//   Modports:
//     master : ROB / surrounding pipeline side (drives retire_*)
//     slave  : commit_rrat side (drives free_*, rec_*, recover_*)
//   Signals:
//     retire_valid/rd/pd/upd/flush  retiring entry from the ROB head
//     free_valid/free_pd            superseded preg returned to free list
//     rec_valid/rec_rd/rec_pd       recovery write into the front RAT
//     recover_busy/recover_done     recovery in progress / finished pulse
//     stat_retired/flushes/freed    only when COMMIT_RRAT_STATS_EN is defined
interface commit_rrat_if;
  import commit_rrat_pkg::*;

  logic                   retire_valid;
  logic [R_REG_DEPTH-1:0] retire_rd;
  logic [P_REG_DEPTH-1:0] retire_pd;
  logic                   retire_upd;
  logic                   retire_flush;

  logic                   free_valid;
  logic [P_REG_DEPTH-1:0] free_pd;

  logic                   rec_valid;
  logic [R_REG_DEPTH-1:0] rec_rd;
  logic [P_REG_DEPTH-1:0] rec_pd;
  logic                   recover_busy;
  logic                   recover_done;

`ifdef COMMIT_RRAT_STATS_EN
  logic [31:0]            stat_retired;
  logic [31:0]            stat_flushes;
  logic [31:0]            stat_freed;

  modport master (
    output retire_valid, retire_rd, retire_pd, retire_upd, retire_flush,
    input  free_valid, free_pd,
    input  rec_valid, rec_rd, rec_pd, recover_busy, recover_done,
    input  stat_retired, stat_flushes, stat_freed
  );

  modport slave (
    input  retire_valid, retire_rd, retire_pd, retire_upd, retire_flush,
    output free_valid, free_pd,
    output rec_valid, rec_rd, rec_pd, recover_busy, recover_done,
    output stat_retired, stat_flushes, stat_freed
  );
`else
  modport master (
    output retire_valid, retire_rd, retire_pd, retire_upd, retire_flush,
    input  free_valid, free_pd,
    input  rec_valid, rec_rd, rec_pd, recover_busy, recover_done
  );

  modport slave (
    input  retire_valid, retire_rd, retire_pd, retire_upd, retire_flush,
    output free_valid, free_pd,
    output rec_valid, rec_rd, rec_pd, recover_busy, recover_done
  );
`endif

endinterface

// File: rtl/commit_rrat.sv
// commit_rrat
//   Retirement stage behind the reorder buffer. Accepts one retired entry
//   per cycle, keeps the retirement RAT (committed arch->phys map), returns
//   each superseded preg to the free list one cycle later, and on a
//   commit-time flush streams the whole RRAT back into the front-end RAT
//   over NUM_AREG cycles while holding dispatch off.
//   Ports:
//     clk  clock
//     rst  synchronous, active-high reset
//     bus  commit_rrat_if.slave (retire in; free, recovery, stats out)
//   Optional feature:
//     COMMIT_RRAT_STATS_EN  adds saturating 32-bit retired/flush/freed
//                           counters on bus.stat_*.
module commit_rrat
  import commit_rrat_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  commit_rrat_if.slave bus
);

  localparam logic [R_REG_DEPTH:0] LP_CNT_LAST = (R_REG_DEPTH+1)'(NUM_AREG - 1);

  retire_entry_t          w_ent;
  commit_state_t          r_state;
  commit_state_t          w_state_nxt;
  logic [R_REG_DEPTH:0]   r_cnt;
  logic [R_REG_DEPTH:0]   w_cnt_nxt;
  logic [P_REG_DEPTH-1:0] r_rrat [NUM_AREG];
  logic                   r_free_valid;
  logic [P_REG_DEPTH-1:0] r_free_pd;
  logic                   r_done;
  logic                   w_accept;
  logic                   w_write;
  logic                   w_last;
  logic                   w_recover;

  always_comb begin
    w_ent.rd    = bus.retire_rd;
    w_ent.pd    = bus.retire_pd;
    w_ent.upd   = bus.retire_upd;
    w_ent.flush = bus.retire_flush;
  end

  // The ROB is already flushed during recovery, so retires are only taken in RUN.
  assign w_recover = (r_state == CS_RECOVER);
  assign w_accept  = bus.retire_valid && !w_recover;
  // x0 is hard-wired to preg 0 and never remapped.
  assign w_write   = w_accept && w_ent.upd && (w_ent.rd != '0);
  assign w_last    = w_recover && (r_cnt == LP_CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CS_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      CS_RUN: begin
        if (w_accept && w_ent.flush) begin
          w_state_nxt = CS_RECOVER;
          w_cnt_nxt   = '0;
        end
      end
      CS_RECOVER: begin
        if (w_last) begin
          w_state_nxt = CS_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = CS_RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // RRAT storage: identity map out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_AREG; i++) begin
        r_rrat[i] <= P_REG_DEPTH'(i);
      end
    end else if (w_write) begin
      r_rrat[w_ent.rd] <= w_ent.pd;
    end
  end

  // Free-list return: the mapping being overwritten, one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_free_valid <= 1'b0;
      r_free_pd    <= '0;
      r_done       <= 1'b0;
    end else begin
      r_free_valid <= w_write;
      if (w_write) begin
        r_free_pd <= r_rrat[w_ent.rd];
      end
      r_done <= w_last;
    end
  end

  assign bus.free_valid   = r_free_valid;
  assign bus.free_pd      = r_free_pd;
  assign bus.rec_valid    = w_recover;
  assign bus.rec_rd       = r_cnt[R_REG_DEPTH-1:0];
  assign bus.rec_pd       = w_recover ? r_rrat[r_cnt[R_REG_DEPTH-1:0]] : '0;
  assign bus.recover_busy = w_recover;
  assign bus.recover_done = r_done;

`ifdef COMMIT_RRAT_STATS_EN
  logic [31:0] r_stat_retired;
  logic [31:0] r_stat_flushes;
  logic [31:0] r_stat_freed;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != '1)) ? (v + 32'd1) : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_retired <= '0;
      r_stat_flushes <= '0;
      r_stat_freed   <= '0;
    end else begin
      r_stat_retired <= sat_inc(r_stat_retired, w_accept);
      r_stat_flushes <= sat_inc(r_stat_flushes, w_accept && w_ent.flush);
      r_stat_freed   <= sat_inc(r_stat_freed, w_write);
    end
  end

  assign bus.stat_retired = r_stat_retired;
  assign bus.stat_flushes = r_stat_flushes;
  assign bus.stat_freed   = r_stat_freed;
`endif

  // Remapping a register onto the preg it already holds would free a live preg.
  a_no_self_remap: assert property (@(posedge clk) disable iff (rst)
    w_write |-> (r_rrat[w_ent.rd] != w_ent.pd));

endmodule

// File: tb/tb_commit_rrat.sv
module tb_commit_rrat;
  import commit_rrat_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  commit_rrat_if bus ();

  commit_rrat dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit       v;
    logic [5:0] pd;
  } free_exp_t;

  int         tests = 0;
  int         fails = 0;
  logic [5:0] m_rrat [32];
  free_exp_t  q_free [$];
  int         m_retired = 0;
  int         m_flushes = 0;
  int         m_freed   = 0;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.retire_valid = 1'b0;
    bus.retire_rd    = '0;
    bus.retire_pd    = '0;
    bus.retire_upd   = 1'b0;
    bus.retire_flush = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rrat[i] = 6'(i);
    q_free.delete();
    m_retired = 0;
    m_flushes = 0;
    m_freed   = 0;
  endtask

  // Drives one retire in RUN state, records the expected free, advances one cycle.
  task automatic drive_retire(input logic [4:0] rd, input logic [5:0] pd,
                              input bit upd, input bit flush);
    free_exp_t e;
    e.v  = upd && (rd != 5'd0);
    e.pd = m_rrat[rd];
    q_free.push_back(e);
    if (e.v) begin
      m_rrat[rd] = pd;
      m_freed++;
    end
    m_retired++;
    if (flush) m_flushes++;
    bus.retire_valid = 1'b1;
    bus.retire_rd    = rd;
    bus.retire_pd    = pd;
    bus.retire_upd   = upd;
    bus.retire_flush = flush;
    tick();
    idle_inputs();
  endtask

  task automatic recovery_sweep(input string tag, input bit inject);
    free_exp_t e;
    for (int i = 0; i < 32; i++) begin
      tests++;
      if (bus.rec_valid !== 1'b1 || bus.rec_rd !== 5'(i) || bus.rec_pd !== m_rrat[i] ||
          bus.recover_busy !== 1'b1 || bus.recover_done !== 1'b0) begin
        fails++;
        $display("FAIL %s_rec[%0d]: got valid=%b rd=%0d pd=%0d busy=%b done=%b, want 1 %0d %0d 1 0",
                 tag, i, bus.rec_valid, bus.rec_rd, bus.rec_pd, bus.recover_busy,
                 bus.recover_done, i, m_rrat[i]);
      end
      if (inject && i == 4) begin
        bus.retire_valid = 1'b1;
        bus.retire_rd    = 5'd3;
        bus.retire_pd    = 6'd60;
        bus.retire_upd   = 1'b1;
        bus.retire_flush = 1'b1;
        e.v  = 1'b0;
        e.pd = '0;
        q_free.push_back(e);
      end
      tick();
      idle_inputs();
      if (inject && i == 4) begin
        e = q_free.pop_front();
        tests++;
        if (bus.free_valid !== e.v) begin
          fails++;
          $display("FAIL %s_ignored_retire: free_valid=%b want %b", tag, bus.free_valid, e.v);
        end
      end
    end
    tests++;
    if (bus.rec_valid !== 1'b0 || bus.recover_busy !== 1'b0 || bus.recover_done !== 1'b1) begin
      fails++;
      $display("FAIL %s_exit: valid=%b busy=%b done=%b want 0 0 1",
               tag, bus.rec_valid, bus.recover_busy, bus.recover_done);
    end
    tick();
    tests++;
    if (bus.recover_done !== 1'b0 || bus.rec_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_done_pulse: done=%b valid=%b want 0 0", tag, bus.recover_done, bus.rec_valid);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    tests++;
    if (bus.free_valid !== 1'b0 || bus.free_pd !== 6'd0 || bus.rec_valid !== 1'b0 ||
        bus.rec_rd !== 5'd0 || bus.rec_pd !== 6'd0 || bus.recover_busy !== 1'b0 ||
        bus.recover_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: fv=%b fpd=%0d rv=%b rrd=%0d rpd=%0d busy=%b done=%b want all 0",
               bus.free_valid, bus.free_pd, bus.rec_valid, bus.rec_rd, bus.rec_pd,
               bus.recover_busy, bus.recover_done);
    end
  endtask

  task automatic test_basic();
    free_exp_t e;
    drive_retire(5'd5, 6'd40, 1'b1, 1'b0);
    e = q_free.pop_front();
    tests++;
    if (bus.free_valid !== e.v || bus.free_pd !== e.pd) begin
      fails++;
      $display("FAIL basic_free: got %b/%0d want %b/%0d", bus.free_valid, bus.free_pd, e.v, e.pd);
    end
    tick();
    tests++;
    if (bus.free_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_pulse: free_valid=%b want 0", bus.free_valid);
    end
  endtask

  task automatic test_back_to_back();
    free_exp_t e;
    drive_retire(5'd5, 6'd41, 1'b1, 1'b0);
    e = q_free.pop_front();
    tests++;
    if (bus.free_valid !== e.v || bus.free_pd !== e.pd) begin
      fails++;
      $display("FAIL b2b_first: got %b/%0d want %b/%0d", bus.free_valid, bus.free_pd, e.v, e.pd);
    end
    drive_retire(5'd5, 6'd42, 1'b1, 1'b0);
    e = q_free.pop_front();
    tests++;
    if (bus.free_valid !== e.v || bus.free_pd !== e.pd) begin
      fails++;
      $display("FAIL b2b_second: got %b/%0d want %b/%0d", bus.free_valid, bus.free_pd, e.v, e.pd);
    end
  endtask

  task automatic test_no_write();
    free_exp_t e;
    drive_retire(5'd0, 6'd50, 1'b1, 1'b0);
    e = q_free.pop_front();
    tests++;
    if (bus.free_valid !== e.v) begin
      fails++;
      $display("FAIL x0_no_free: free_valid=%b want %b", bus.free_valid, e.v);
    end
    drive_retire(5'd6, 6'd45, 1'b0, 1'b0);
    e = q_free.pop_front();
    tests++;
    if (bus.free_valid !== e.v) begin
      fails++;
      $display("FAIL noupd_no_free: free_valid=%b want %b", bus.free_valid, e.v);
    end
  endtask

  task automatic test_flush_recovery();
    free_exp_t e;
    drive_retire(5'd7, 6'd33, 1'b1, 1'b1);
    e = q_free.pop_front();
    tests++;
    if (bus.free_valid !== e.v || bus.free_pd !== e.pd) begin
      fails++;
      $display("FAIL flush_free: got %b/%0d want %b/%0d", bus.free_valid, bus.free_pd, e.v, e.pd);
    end
    recovery_sweep("flush", 1'b1);
    // rd=3 must still hold its pre-recovery mapping.
    drive_retire(5'd3, 6'd61, 1'b1, 1'b0);
    e = q_free.pop_front();
    tests++;
    if (bus.free_valid !== e.v || bus.free_pd !== e.pd) begin
      fails++;
      $display("FAIL rd3_unchanged: got %b/%0d want %b/%0d", bus.free_valid, bus.free_pd, e.v, e.pd);
    end
  endtask

  task automatic test_random();
    free_exp_t  e;
    logic [4:0] rd;
    logic [5:0] pd;
    bit         upd;
    for (int n = 0; n < 24; n++) begin
      rd  = 5'($urandom_range(0, 31));
      pd  = 6'($urandom_range(32, 63));
      if (pd == m_rrat[rd]) pd = pd ^ 6'd1;
      upd = ($urandom_range(0, 3) != 0);
      drive_retire(rd, pd, upd, 1'b0);
      e = q_free.pop_front();
      tests++;
      if (bus.free_valid !== e.v || (e.v && bus.free_pd !== e.pd)) begin
        fails++;
        $display("FAIL rand_free[%0d]: got %b/%0d want %b/%0d",
                 n, bus.free_valid, bus.free_pd, e.v, e.pd);
      end
    end
    rd = 5'd11;
    pd = (m_rrat[11] == 6'd35) ? 6'd36 : 6'd35;
    drive_retire(rd, pd, 1'b1, 1'b1);
    e = q_free.pop_front();
    tests++;
    if (bus.free_valid !== e.v || bus.free_pd !== e.pd) begin
      fails++;
      $display("FAIL rand_flush_free: got %b/%0d want %b/%0d", bus.free_valid, bus.free_pd, e.v, e.pd);
    end
    recovery_sweep("rand", 1'b0);
  endtask

  task automatic test_reset_mid_recovery();
    free_exp_t e;
    int        waited;
    drive_retire(5'd9, 6'd34, 1'b1, 1'b1);
    e = q_free.pop_front();
    tests++;
    if (bus.free_valid !== e.v || bus.free_pd !== e.pd) begin
      fails++;
      $display("FAIL midrst_free: got %b/%0d want %b/%0d", bus.free_valid, bus.free_pd, e.v, e.pd);
    end
    waited = 0;
    while (!(bus.rec_valid === 1'b1 && bus.rec_rd === 5'd12) && waited < 40) begin
      tick();
      waited++;
    end
    tests++;
    if (bus.rec_valid !== 1'b1 || bus.rec_rd !== 5'd12) begin
      fails++;
      $display("FAIL midrst_reach12: rec_valid=%b rec_rd=%0d want 1 12", bus.rec_valid, bus.rec_rd);
    end
    rst = 1'b1;
    tick();
    tests++;
    if (bus.rec_valid !== 1'b0 || bus.recover_busy !== 1'b0 || bus.free_valid !== 1'b0 ||
        bus.recover_done !== 1'b0) begin
      fails++;
      $display("FAIL midrst_abort: rv=%b busy=%b fv=%b done=%b want 0 0 0 0",
               bus.rec_valid, bus.recover_busy, bus.free_valid, bus.recover_done);
    end
    rst = 1'b0;
    model_reset();
    // Flush without a register write: recovery with no free, identity map expected.
    drive_retire(5'd1, 6'd0, 1'b0, 1'b1);
    e = q_free.pop_front();
    tests++;
    if (bus.free_valid !== e.v) begin
      fails++;
      $display("FAIL noupd_flush_free: free_valid=%b want %b", bus.free_valid, e.v);
    end
    recovery_sweep("identity", 1'b0);
  endtask

`ifdef COMMIT_RRAT_STATS_EN
  task automatic test_stats();
    tests++;
    if (bus.stat_retired !== 32'(m_retired) || bus.stat_flushes !== 32'(m_flushes) ||
        bus.stat_freed !== 32'(m_freed)) begin
      fails++;
      $display("FAIL stats: got %0d/%0d/%0d want %0d/%0d/%0d",
               bus.stat_retired, bus.stat_flushes, bus.stat_freed, m_retired, m_flushes, m_freed);
    end
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_back_to_back();
    test_no_write();
    test_flush_recovery();
    test_random();
    test_reset_mid_recovery();
`ifdef COMMIT_RRAT_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
